mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one unified single-port memory between the IF-stage instruction fetch and the MEM-stage data access of the 5-stage RISC-V pipeline.
- Sequences one transaction at a time over a valid/ready request channel with a variable-latency response.
- Drives per-requester stall signals, ORed by the pipeline into the existing stall network.
- Data access has priority; a starvation guard ensures fetch still makes progress.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width (byte enables are DATA_W/8).
- MAX_D_BURST, 4, max consecutive data grants while fetch waits; range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request (level; held until if_stall low).
- if_addr  in  ADDR_W  fetch address.
- if_rdata  out  DATA_W  fetched instruction; valid when if_req && !if_stall.
- if_stall  out  1  fetch not complete.
- dm_req  in  1  data request (level).
- dm_we  in  1  1 = store.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  store data.
- dm_be  in  DATA_W/8  store byte enables.
- dm_rdata  out  DATA_W  load data; valid when dm_req && !dm_stall.
- dm_stall  out  1  data access not complete.
- mem_valid  out  1  request valid.
- mem_ready  in  1  memory accepts request.
- mem_we, mem_addr, mem_wdata, mem_be  out  1/ADDR_W/DATA_W/DATA_W/8  request fields, registered at grant.
- mem_rvalid  in  1  response/ack; also returned for writes.
- mem_rdata  in  DATA_W  read data.

Behaviour:
- Reset (async): state IDLE; mem_valid=0; mem_we/addr/wdata/be=0; if_rdata=dm_rdata=0; burst_cnt=0; owner=IF.
- States: IDLE, REQ, WAIT, DONE.
- Stall rules:
  - if_stall = if_req && !(state==DONE && owner==IF).
  - dm_stall = dm_req && !(state==DONE && owner==DM).
  - Both are combinational from registered state.
- IDLE grant:
  - Grant DM if dm_req && (!if_req || burst_cnt<MAX_D_BURST).
  - Else grant IF if if_req.
  - On grant, register owner and request fields, then go to REQ.
  - No request: stay IDLE.
- REQ:
  - mem_valid=1 with fields held stable until mem_ready.
  - mem_ready && !mem_rvalid -> WAIT.
  - mem_ready && mem_rvalid in the same cycle (zero-latency memory) -> DONE, capturing rdata.
  - mem_rvalid without mem_ready is ignored.
- WAIT: mem_valid=0; on mem_rvalid capture mem_rdata into the owner's rdata register, then go to DONE.
- DONE:
  - Exactly one cycle; owner's stall is low, so the pipeline advances.
  - Next state is IDLE.
  - Minimum 3 cycles per access (IDLE, REQ, DONE); a back-to-back request re-arbitrates in IDLE.
- burst_cnt:
  - Increments (saturating at 15) on each DM grant made while if_req=1.
  - Clears on any IF grant or when if_req=0 in IDLE.
- Withdrawal:
  - If the owner drops its req in REQ or WAIT (IF redirect on branch/jalr), the transaction still completes on the memory side.
  - The response is captured but not delivered; DONE still lasts one cycle and the stall output is 0 because req=0.
- A store's rdata register holds its previous value.
- Fields are latched at grant; requester input changes after grant are ignored until DONE.
- Reset mid-transaction: immediate return to IDLE; the memory model must be reset by the same rst.
- The arbiter never issues while state!=IDLE: at most one outstanding transaction.

Optional Feature:
- Macro: MEM_ARB_PERF_CNT_EN.
- With it defined:
  - Ports if_stall_cnt and dm_stall_cnt (out, 32) are added.
  - Each counts cycles its stall output is 1; wraps at 2^32; cleared by rst.
- Without it: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package mem_arb_pkg holds:
  - state encoding IDLE=2'd0, REQ=2'd1, WAIT=2'd2, DONE=2'd3;
  - owner encoding OWN_IF=1'b0, OWN_DM=1'b1;
  - MAX_BURST_CNT_W=4.
- One natural sub-module: mem_arb_perf_cnt, a stall cycle counter instantiated twice only under MEM_ARB_PERF_CNT_EN.

Test Plan:
- Fetch only, memory latency 2: if_req=1, if_addr=0x100, mem_rdata=0x00500093 -> mem_valid 1 cycle after grant; if_stall low exactly 1 cycle later, with if_rdata=0x00500093.
- Conflict: if_req and dm_req (load 0x2000) both asserted in IDLE -> DM granted first; IF is granted in the following IDLE; dm_stall drops before if_stall.
- Starvation: dm_req held continuously with if_req=1, MAX_D_BURST=4 -> grants DM,DM,DM,DM,IF,DM...; burst_cnt returns to 0 after the IF grant.
- Backpressure and store:
  - Setup: mem_ready low 3 cycles during a store to 0x3000, wdata 0xDEADBEEF, be=4'b0011.
  - Response: fields stable all 3 cycles; dm_rdata unchanged; completes on ack.
- Withdrawal and reset:
  - if_req dropped in WAIT -> response absorbed, no stall, and the next IDLE grant is correct.
  - rst pulsed in WAIT -> outputs return to reset values asynchronously.
- With MEM_ARB_PERF_CNT_EN: the conflict scenario yields if_stall_cnt and dm_stall_cnt equal to the bench's independent stall-cycle tally.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared state/owner encodings and burst counter helper for mem_port_arbiter
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } arb_state_t;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_DM = 1'b1
   } arb_owner_t;

   localparam int MAX_BURST_CNT_W = 4;

   function automatic logic [MAX_BURST_CNT_W-1:0] burst_sat_inc(input logic [MAX_BURST_CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - pipeline-side and memory-side signal bundle of the unified memory port
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic                  if_req;
   logic [ADDR_W-1:0]     if_addr;
   logic [DATA_W-1:0]     if_rdata;
   logic                  if_stall;
   logic                  dm_req;
   logic                  dm_we;
   logic [ADDR_W-1:0]     dm_addr;
   logic [DATA_W-1:0]     dm_wdata;
   logic [DATA_W/8-1:0]   dm_be;
   logic [DATA_W-1:0]     dm_rdata;
   logic                  dm_stall;
   logic                  mem_valid;
   logic                  mem_ready;
   logic                  mem_we;
   logic [ADDR_W-1:0]     mem_addr;
   logic [DATA_W-1:0]     mem_wdata;
   logic [DATA_W/8-1:0]   mem_be;
   logic                  mem_rvalid;
   logic [DATA_W-1:0]     mem_rdata;

   modport master (
      input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_be,
      input  mem_ready, mem_rvalid, mem_rdata,
      output if_rdata, if_stall, dm_rdata, dm_stall,
      output mem_valid, mem_we, mem_addr, mem_wdata, mem_be
   );

   modport slave (
      output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_be,
      output mem_ready, mem_rvalid, mem_rdata,
      input  if_rdata, if_stall, dm_rdata, dm_stall,
      input  mem_valid, mem_we, mem_addr, mem_wdata, mem_be
   );

endinterface

// File: rtl/mem_port_arbiter_perf_cnt.sv
// rtl/mem_port_arbiter_perf_cnt.sv - free-running 32-bit stall cycle counter, wraps on overflow
module mem_arb_perf_cnt (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_en,
   output logic [31:0] o_cnt
);

   logic [31:0] r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= r_cnt + 32'd1;
      end
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - IF/MEM arbiter for a unified single-port memory; MEM_ARB_PERF_CNT_EN adds stall cycle counters
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int MAX_D_BURST = 4
) (
   input  logic                clk,
   input  logic                rst,
   mem_port_arbiter_if.master  bus
`ifdef MEM_ARB_PERF_CNT_EN
   ,
   output logic [31:0]         if_stall_cnt,
   output logic [31:0]         dm_stall_cnt
`endif
);

   localparam logic [MAX_BURST_CNT_W-1:0] LP_MAX_BURST = MAX_BURST_CNT_W'(MAX_D_BURST);

   arb_state_t                   r_state;
   arb_owner_t                   r_owner;
   logic [MAX_BURST_CNT_W-1:0]   r_burst_cnt;
   logic                         r_mem_valid;
   logic                         r_mem_we;
   logic [ADDR_W-1:0]            r_mem_addr;
   logic [DATA_W-1:0]            r_mem_wdata;
   logic [DATA_W/8-1:0]          r_mem_be;
   logic [DATA_W-1:0]            r_if_rdata;
   logic [DATA_W-1:0]            r_dm_rdata;

   logic w_grant_dm;
   logic w_resp;

   // Fetch is only held off while data has not yet used up its burst allowance.
   assign w_grant_dm = bus.dm_req && (!bus.if_req || (r_burst_cnt < LP_MAX_BURST));
   assign w_resp     = ((r_state == REQ) && bus.mem_ready && bus.mem_rvalid) ||
                       ((r_state == WAIT) && bus.mem_rvalid);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_owner     <= OWN_IF;
         r_burst_cnt <= '0;
         r_mem_valid <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_mem_be    <= '0;
         r_if_rdata  <= '0;
         r_dm_rdata  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_grant_dm) begin
                  r_owner     <= OWN_DM;
                  r_mem_we    <= bus.dm_we;
                  r_mem_addr  <= bus.dm_addr;
                  r_mem_wdata <= bus.dm_wdata;
                  r_mem_be    <= bus.dm_be;
                  r_mem_valid <= 1'b1;
                  r_state     <= REQ;
                  r_burst_cnt <= bus.if_req ? burst_sat_inc(r_burst_cnt) : '0;
               end else if (bus.if_req) begin
                  r_owner     <= OWN_IF;
                  r_mem_we    <= 1'b0;
                  r_mem_addr  <= bus.if_addr;
                  r_mem_wdata <= '0;
                  r_mem_be    <= '1;
                  r_mem_valid <= 1'b1;
                  r_state     <= REQ;
                  r_burst_cnt <= '0;
               end else begin
                  r_burst_cnt <= '0;
               end
            end
            REQ: begin
               if (bus.mem_ready) begin
                  r_mem_valid <= 1'b0;
                  r_state     <= bus.mem_rvalid ? DONE : WAIT;
               end
            end
            WAIT: begin
               if (bus.mem_rvalid) begin
                  r_state <= DONE;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase

         // Captured even if the owner withdrew; stores leave rdata untouched.
         if (w_resp && !r_mem_we) begin
            if (r_owner == OWN_DM) begin
               r_dm_rdata <= bus.mem_rdata;
            end else begin
               r_if_rdata <= bus.mem_rdata;
            end
         end
      end
   end

   assign bus.if_stall  = bus.if_req && !((r_state == DONE) && (r_owner == OWN_IF));
   assign bus.dm_stall  = bus.dm_req && !((r_state == DONE) && (r_owner == OWN_DM));
   assign bus.if_rdata  = r_if_rdata;
   assign bus.dm_rdata  = r_dm_rdata;
   assign bus.mem_valid = r_mem_valid;
   assign bus.mem_we    = r_mem_we;
   assign bus.mem_addr  = r_mem_addr;
   assign bus.mem_wdata = r_mem_wdata;
   assign bus.mem_be    = r_mem_be;

`ifdef MEM_ARB_PERF_CNT_EN
   mem_arb_perf_cnt u_if_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .i_en  (bus.if_stall),
      .o_cnt (if_stall_cnt)
   );

   mem_arb_perf_cnt u_dm_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .i_en  (bus.dm_stall),
      .o_cnt (dm_stall_cnt)
   );
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed-vector bench for mem_port_arbiter with a variable-latency memory model
module tb_mem_port_arbiter;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

`ifdef MEM_ARB_PERF_CNT_EN
   logic [31:0] if_cnt;
   logic [31:0] dm_cnt;
`endif

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_D_BURST(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus)
`ifdef MEM_ARB_PERF_CNT_EN
      ,
      .if_stall_cnt (if_cnt),
      .dm_stall_cnt (dm_cnt)
`endif
   );

   int vectors     = 0;
   int miscompares = 0;
   int lat         = 1;
   int stall_left  = 0;
   logic [31:0] mem_data [logic [31:0]];
   int t_if = 0;
   int t_dm = 0;

   task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      if (mem_data.exists(a)) return mem_data[a];
      return {16'hC0DE, a[15:0]};
   endfunction

   // Stall tally sampled on the pre-edge value, same instant the DUT counters would count.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         t_if <= 0;
         t_dm <= 0;
      end else begin
         if (bus.if_stall) t_if <= t_if + 1;
         if (bus.dm_stall) t_dm <= t_dm + 1;
      end
   end

   // Memory model: sets ready/rvalid at each negedge for the next rising edge.
   initial begin
      bit          waiting;
      int          cd;
      logic [31:0] pend;
      logic [31:0] old;
      waiting = 1'b0;
      cd = 0;
      pend = '0;
      bus.mem_ready  = 1'b0;
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = '0;
      forever begin
         @(negedge clk);
         bus.mem_ready  = 1'b0;
         bus.mem_rvalid = 1'b0;
         if (rst) begin
            waiting = 1'b0;
         end else if (waiting) begin
            if (cd == 1) begin
               bus.mem_rvalid = 1'b1;
               bus.mem_rdata  = pend;
               waiting = 1'b0;
            end else begin
               cd--;
            end
         end else if (bus.mem_valid) begin
            if (stall_left > 0) begin
               stall_left--;
            end else begin
               bus.mem_ready = 1'b1;
               if (bus.mem_we) begin
                  old = mem_rd(bus.mem_addr);
                  for (int b = 0; b < 4; b++)
                     if (bus.mem_be[b]) old[b*8 +: 8] = bus.mem_wdata[b*8 +: 8];
                  mem_data[bus.mem_addr] = old;
                  pend = 32'h0BAD0BAD;
               end else begin
                  pend = mem_rd(bus.mem_addr);
               end
               if (lat == 0) begin
                  bus.mem_rvalid = 1'b1;
                  bus.mem_rdata  = pend;
               end else begin
                  waiting = 1'b1;
                  cd = lat;
               end
            end
         end
      end
   end

   task automatic wait_done(input bit dm, input int max, output int cyc);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while ((dm ? bus.dm_stall : bus.if_stall) && cyc < max);
      if (dm ? bus.dm_stall : bus.if_stall) check_vec("wait_timeout", 32'd1, 32'd0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int   cyc;
      int   dm_at;
      int   if_at;
      bit   prev_valid;
      int   ng;
      logic [31:0] exp_grant [10];
      logic [31:0] got_grant [10];

      bus.if_req = 0; bus.if_addr = 0;
      bus.dm_req = 0; bus.dm_we = 0; bus.dm_addr = 0; bus.dm_wdata = 0; bus.dm_be = 0;
      mem_data[32'h100]  = 32'h00500093;
      mem_data[32'h200]  = 32'hCAFEF00D;
      mem_data[32'h2000] = 32'h11223344;
      mem_data[32'h2004] = 32'h55667788;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      check_vec("rst_mem_valid", bus.mem_valid, 0);
      check_vec("rst_mem_we",    bus.mem_we, 0);
      check_vec("rst_mem_addr",  bus.mem_addr, 0);
      check_vec("rst_mem_wdata", bus.mem_wdata, 0);
      check_vec("rst_mem_be",    bus.mem_be, 0);
      check_vec("rst_if_rdata",  bus.if_rdata, 0);
      check_vec("rst_dm_rdata",  bus.dm_rdata, 0);
      check_vec("rst_stalls",    {bus.if_stall, bus.dm_stall}, 0);

      // Fetch only, latency 2
      lat = 2;
      bus.if_req = 1; bus.if_addr = 32'h100;
      #1 check_vec("f_stall_req", bus.if_stall, 1);
      @(negedge clk);
      check_vec("f_valid",  bus.mem_valid, 1);
      check_vec("f_addr",   bus.mem_addr, 32'h100);
      check_vec("f_we",     bus.mem_we, 0);
      wait_done(0, 20, cyc);
      check_vec("f_latency", cyc, 3);
      check_vec("f_rdata",   bus.if_rdata, 32'h00500093);
      @(negedge clk);
      check_vec("f_stall_1cyc", bus.if_stall, 1);
      bus.if_req = 0;
      @(negedge clk);

      // Conflict: data wins, fetch follows
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      lat = 1;
      bus.if_req = 1; bus.if_addr = 32'h104;
      bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 32'h2000;
      dm_at = 0; if_at = 0; cyc = 0;
      while ((bus.if_req || bus.dm_req) && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) check_vec("c_first_addr", bus.mem_addr, 32'h2000);
         if (bus.dm_req && !bus.dm_stall) begin
            dm_at = cyc;
            check_vec("c_dm_rdata", bus.dm_rdata, 32'h11223344);
            bus.dm_req = 0;
         end
         if (bus.if_req && !bus.if_stall) begin
            if_at = cyc;
            check_vec("c_if_rdata", bus.if_rdata, 32'hC0DE0104);
            bus.if_req = 0;
         end
      end
      check_vec("c_dm_done_at", dm_at, 3);
      check_vec("c_if_done_at", if_at, 7);
      @(negedge clk);
`ifdef MEM_ARB_PERF_CNT_EN
      check_vec("c_if_cnt_tally", if_cnt, t_if);
      check_vec("c_dm_cnt_tally", dm_cnt, t_dm);
      check_vec("c_if_cnt_val",   if_cnt, 7);
      check_vec("c_dm_cnt_val",   dm_cnt, 3);
`endif

      // Starvation guard: DDDDI DDDDI with both requests held
      lat = 0;
      exp_grant = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
      bus.if_req = 1; bus.if_addr = 32'h100;
      bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 32'h2000;
      prev_valid = 0; ng = 0; cyc = 0;
      while (ng < 10 && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (bus.mem_valid && !prev_valid) begin
            got_grant[ng] = (bus.mem_addr == 32'h2000) ? 32'd1 : 32'd0;
            ng++;
         end
         prev_valid = bus.mem_valid;
      end
      bus.if_req = 0; bus.dm_req = 0;
      check_vec("s_grant_count", ng, 10);
      for (int i = 0; i < ng; i++) check_vec($sformatf("s_grant%0d", i), got_grant[i], exp_grant[i]);
      repeat (4) @(negedge clk);

      // Store under backpressure
      lat = 1; stall_left = 3;
      bus.dm_req = 1; bus.dm_we = 1; bus.dm_addr = 32'h3000;
      bus.dm_wdata = 32'hDEADBEEF; bus.dm_be = 4'b0011;
      @(negedge clk);
      bus.dm_addr = 32'h3004; bus.dm_wdata = 32'h0; bus.dm_be = 4'b1100;
      for (int i = 0; i < 3; i++) begin
         check_vec($sformatf("b_valid%0d", i), bus.mem_valid, 1);
         check_vec($sformatf("b_fields%0d", i), {bus.mem_we, bus.mem_be, bus.mem_addr[23:0]}, {1'b1, 4'b0011, 24'h003000});
         check_vec($sformatf("b_wdata%0d", i), bus.mem_wdata, 32'hDEADBEEF);
         @(negedge clk);
      end
      wait_done(1, 20, cyc);
      check_vec("b_ack_cycles", cyc, 2);
      check_vec("b_dm_rdata",   bus.dm_rdata, 32'h11223344);
      check_vec("b_mem_word",   mem_rd(32'h3000), 32'hC0DEBEEF);
      bus.dm_req = 0; bus.dm_we = 0;
      @(negedge clk);

      // Fetch withdrawn during WAIT
      lat = 3;
      bus.if_req = 1; bus.if_addr = 32'h200;
      repeat (2) @(negedge clk);
      check_vec("w_in_wait", bus.mem_valid, 0);
      bus.if_req = 0;
      for (int i = 0; i < 5; i++) begin
         #1 check_vec($sformatf("w_no_stall%0d", i), bus.if_stall, 0);
         @(negedge clk);
      end
      check_vec("w_absorbed", bus.if_rdata, 32'hCAFEF00D);
      lat = 1;
      bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 32'h2004;
      @(negedge clk);
      check_vec("w_next_grant", {bus.mem_valid, bus.mem_we, bus.mem_addr[15:0]}, {2'b10, 16'h2004});
      wait_done(1, 20, cyc);
      check_vec("w_next_rdata", bus.dm_rdata, 32'h55667788);
      bus.dm_req = 0;
      @(negedge clk);

      // Asynchronous reset while waiting on a load
      lat = 4;
      bus.dm_req = 1; bus.dm_addr = 32'h2000;
      repeat (2) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check_vec("r_mem_addr", bus.mem_addr, 0);
      check_vec("r_dm_rdata", bus.dm_rdata, 0);
      check_vec("r_if_rdata", bus.if_rdata, 0);
      check_vec("r_mem_be",   bus.mem_be, 0);
      bus.dm_req = 0;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check_vec($sformatf("r_quiet%0d", i), {bus.mem_valid, bus.dm_stall, bus.dm_rdata[0]}, 0);
      end
      lat = 1;
      bus.if_req = 1; bus.if_addr = 32'h100;
      wait_done(0, 20, cyc);
      check_vec("r_refetch", bus.if_rdata, 32'h00500093);
      bus.if_req = 0;
      repeat (2) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
